param_fifo: RTL and testbench
=============================

PARAM_FIFO -- requirements
Module: param_fifo

Interface
REQ-001 Parameter WIDTH, default 8, data word width in bits (>=1).
REQ-002 Parameter DEPTH, default 8, entry count; power of two, >=2.
REQ-003 Parameter AF_LEVEL, default DEPTH-1, almost-full threshold (1..DEPTH).
REQ-004 Parameter AE_LEVEL, default 1, almost-empty threshold (0..DEPTH-1).
REQ-005 Derived constant AW = log2(DEPTH), computed from DEPTH, never hand-coded.
REQ-006 clk  input  1  rising-edge clock.
REQ-007 resetn  input  1  reset, synchronous, active-low.
REQ-008 flush  input  1  synchronous empty request.
REQ-009 push  input  1  write request.
REQ-010 inData  input  WIDTH  write data.
REQ-011 notfull  output  1  FIFO can accept a write.
REQ-012 pop  input  1  read request.
REQ-013 outData  output  WIDTH  read data.
REQ-014 notempty  output  1  FIFO holds at least one word.
REQ-015 level  output  AW+1  current occupancy, 0..DEPTH.
REQ-016 almostFull  output  1  level >= AF_LEVEL.
REQ-017 almostEmpty  output  1  level <= AE_LEVEL.
REQ-018 overflow  output  1  sticky: push attempted while full.
REQ-019 underflow  output  1  sticky: pop attempted while empty.

Function
REQ-020 Write accepted iff push & notfull; read accepted iff pop & notempty; refused requests change no state except the sticky flags.
REQ-021 level, notfull, notempty, almostFull and almostEmpty are registered; all reflect occupancy after the current edge, with no extra cycle of lag.
REQ-022 Accepted write only: level+1; accepted read only: level-1; both accepted: level unchanged, one word written, head word consumed.
REQ-023 At full with push & pop: push refused (overflow set), pop accepted, level = DEPTH-1.
REQ-024 At empty with push & pop: pop refused (underflow set), push accepted, level = 1.
REQ-025 Write and read pointers are AW bits wide and wrap DEPTH-1 -> 0 without a gap.
REQ-026 flush clears pointers, level, overflow and underflow on the same edge; it takes priority over same-cycle push/pop, both of which are ignored; storage contents are not cleared.
REQ-027 outData holds its last value when no read is accepted; it is never zeroed on idle.

Reset
REQ-028 With resetn low at an edge: pointers=0, level=0, notfull=1, notempty=0, almostFull=0, almostEmpty=(AE_LEVEL>=0)=1, overflow=0, underflow=0, outData=0.
REQ-029 Reset mid-operation discards all stored words; the first cycle after release behaves as empty.

Configuration
REQ-030 Macro PARAM_FIFO_FWFT_EN selects first-word-fall-through read mode.
REQ-031 With PARAM_FIFO_FWFT_EN defined: outData presents the head word combinationally whenever notempty=1; pop consumes it, and the next word appears in the same cycle after the edge.
REQ-032 Without it: outData is registered; the head word loads on the edge where a read is accepted, so data is valid one cycle after pop.

Structure
REQ-033 Shared package param_fifo_pkg holds the log2 function and default parameter constants.
REQ-034 Storage is a single sub-module param_fifo_ram: DEPTH x WIDTH flop RAM, one synchronous write port, one asynchronous read port; it has no reset.

Verification
REQ-035 DEPTH=8: reset, then 8 pushes 0x01..0x08 -> level=8, notfull=0, almostFull=1 from the 7th push.
REQ-036 Full FIFO, 9th push -> data unchanged, overflow=1 until flush; 8 pops return 0x01..0x08 in order, notempty=0 after the last.
REQ-037 Empty FIFO, pop -> underflow=1, level stays 0; simultaneous push 0xA5/pop -> level=1, underflow=1.
REQ-038 Level 4, push & pop every cycle for 20 cycles -> level stays 4, pointers wrap, output order preserved.
REQ-039 Level 5 with flush & push asserted together -> next cycle level=0, notempty=0, flags clear; the pushed word is discarded.
REQ-040 Run REQ-035/036 with and without PARAM_FIFO_FWFT_EN -> 0x01 appears on outData the cycle after the first push (FWFT) or the cycle after the first pop (registered).

Source files
------------

// File: rtl/param_fifo_pkg.sv
// param_fifo_pkg: shared defaults and the log2 helper for the param_fifo slice.
package param_fifo_pkg;
   localparam int DEF_WIDTH = 8;
   localparam int DEF_DEPTH = 8;
   function automatic int log2(input int n);
      int r = 0;
      for (int v = n - 1; v > 0; v = v >> 1) r++;
      return r;
   endfunction
endpackage

// File: rtl/param_fifo_ram.sv
// param_fifo_ram: DEPTH x WIDTH flop storage, synchronous write, asynchronous read, no reset.
module param_fifo_ram #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 8,
   parameter int AW    = 3
) (
   input  logic             clk,
   input  logic             we_i,
   input  logic [AW-1:0]    waddr_i,
   input  logic [WIDTH-1:0] wdata_i,
   input  logic [AW-1:0]    raddr_i,
   output logic [WIDTH-1:0] rdata_o
);
   logic [WIDTH-1:0] mem_q [DEPTH];
   always_ff @(posedge clk)
      if (we_i) mem_q[waddr_i] <= wdata_i;
   assign rdata_o = mem_q[raddr_i];
endmodule

// File: rtl/param_fifo.sv
// param_fifo: synchronous FIFO with registered level/flags and sticky overflow/underflow.
// Define PARAM_FIFO_FWFT_EN for first-word-fall-through reads; default is registered read data.
module param_fifo
   import param_fifo_pkg::*;
#(
   parameter int WIDTH    = DEF_WIDTH,
   parameter int DEPTH    = DEF_DEPTH,
   parameter int AF_LEVEL = DEPTH - 1,
   parameter int AE_LEVEL = 1
) (
   input  logic                     clk,
   input  logic                     resetn,
   input  logic                     flush,
   input  logic                     push,
   input  logic [WIDTH-1:0]         inData,
   output logic                     notfull,
   input  logic                     pop,
   output logic [WIDTH-1:0]         outData,
   output logic                     notempty,
   output logic [log2(DEPTH):0]     level,
   output logic                     almostFull,
   output logic                     almostEmpty,
   output logic                     overflow,
   output logic                     underflow
);
   localparam int AW = log2(DEPTH);
   localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
   localparam logic [AW:0] AFL  = (AW+1)'(AF_LEVEL);
   localparam logic [AW:0] AEL  = (AW+1)'(AE_LEVEL);

   logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [AW:0]      level_q, level_d;
   logic             notfull_q, notfull_d, notempty_q, notempty_d;
   logic             af_q, af_d, ae_q, ae_d, ovf_q, ovf_d, unf_q, unf_d;
   logic [WIDTH-1:0] out_q, out_d, rdata;
   logic             wr_en, rd_en;

   assign wr_en = push & notfull_q & ~flush;
   assign rd_en = pop & notempty_q & ~flush;

   param_fifo_ram #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW)) u_ram (
      .clk     (clk),
      .we_i    (wr_en),
      .waddr_i (wr_ptr_q),
      .wdata_i (inData),
      .raddr_i (rd_ptr_q),
      .rdata_o (rdata)
   );

   // Flags are derived from next-state level so they never lag occupancy.
   always_comb begin
      wr_ptr_d   = flush ? '0 : wr_ptr_q + AW'(wr_en);
      rd_ptr_d   = flush ? '0 : rd_ptr_q + AW'(rd_en);
      level_d    = flush ? '0 : level_q + (AW+1)'(wr_en) - (AW+1)'(rd_en);
      ovf_d      = ~flush & (ovf_q | (push & ~notfull_q));
      unf_d      = ~flush & (unf_q | (pop & ~notempty_q));
      out_d      = rd_en ? rdata : out_q;
      notfull_d  = level_d != FULL;
      notempty_d = level_d != '0;
      af_d       = level_d >= AFL;
      ae_d       = level_d <= AEL;
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         level_q    <= '0;
         notfull_q  <= 1'b1;
         notempty_q <= 1'b0;
         af_q       <= 1'b0;
         ae_q       <= 1'b1;
         ovf_q      <= 1'b0;
         unf_q      <= 1'b0;
         out_q      <= '0;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         level_q    <= level_d;
         notfull_q  <= notfull_d;
         notempty_q <= notempty_d;
         af_q       <= af_d;
         ae_q       <= ae_d;
         ovf_q      <= ovf_d;
         unf_q      <= unf_d;
         out_q      <= out_d;
      end
   end

   assign level       = level_q;
   assign notfull     = notfull_q;
   assign notempty    = notempty_q;
   assign almostFull  = af_q;
   assign almostEmpty = ae_q;
   assign overflow    = ovf_q;
   assign underflow   = unf_q;
`ifdef PARAM_FIFO_FWFT_EN
   // out_q keeps the last consumed word so an empty FWFT FIFO still holds its output.
   assign outData = notempty_q ? rdata : out_q;
`else
   assign outData = out_q;
`endif
endmodule

// File: tb/tb_param_fifo.sv
// tb_param_fifo: randomized scoreboard bench for param_fifo against a queue-based reference model.
module tb_param_fifo;
   localparam int W = 8, D = 8, AF = 7, AE = 1;

   logic clk = 1'b0, resetn = 1'b0, flush = 1'b0, push = 1'b0, pop = 1'b0;
   logic [W-1:0] inData = '0;
   logic notfull, notempty, almostFull, almostEmpty, overflow, underflow;
   logic [W-1:0] outData;
   logic [3:0] level;

   param_fifo #(.WIDTH(W), .DEPTH(D), .AF_LEVEL(AF), .AE_LEVEL(AE)) dut (
      .clk(clk), .resetn(resetn), .flush(flush), .push(push), .inData(inData),
      .notfull(notfull), .pop(pop), .outData(outData), .notempty(notempty),
      .level(level), .almostFull(almostFull), .almostEmpty(almostEmpty),
      .overflow(overflow), .underflow(underflow)
   );

   always #5 clk = ~clk;

   int checks = 0, errors = 0;
   logic [W-1:0] mq[$];
   logic [W-1:0] exp_q[$];
   bit m_ovf = 0, m_unf = 0;

   task automatic chk(string n, logic [31:0] act, logic [31:0] expv);
      checks++;
      if (act !== expv) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", n, act, expv, $time);
      end
   endtask

   // Drive one cycle of inputs, advance the model, then check registered status after the edge.
   task automatic step(bit rn, bit fl, bit pu, bit po, logic [W-1:0] d);
      bit rd, wr;
      int n;
      resetn = rn; flush = fl; push = pu; pop = po; inData = d;
      if (!rn || fl) begin
         mq.delete();
         m_ovf = 0;
         m_unf = 0;
      end else begin
         rd = po && mq.size() > 0;
         wr = pu && mq.size() < D;
         if (pu && !wr) m_ovf = 1;
         if (po && !rd) m_unf = 1;
         if (rd) exp_q.push_back(mq.pop_front());
         if (wr) mq.push_back(d);
      end
      @(posedge clk);
      #1;
      n = mq.size();
      chk("level", 32'(level), 32'(n));
      chk("notfull", 32'(notfull), 32'(n < D));
      chk("notempty", 32'(notempty), 32'(n > 0));
      chk("almostFull", 32'(almostFull), 32'(n >= AF));
      chk("almostEmpty", 32'(almostEmpty), 32'(n <= AE));
      chk("overflow", 32'(overflow), 32'(m_ovf));
      chk("underflow", 32'(underflow), 32'(m_unf));
      #1;
   endtask

   // Monitor: every accepted read must deliver the next scoreboard word.
   initial begin
      bit fire;
      logic [W-1:0] d;
      forever begin
         @(negedge clk);
         fire = resetn && !flush && pop && notempty === 1'b1;
`ifdef PARAM_FIFO_FWFT_EN
         d = outData;
         @(posedge clk);
`else
         @(posedge clk);
         #1;
         d = outData;
`endif
         if (fire) begin
            if (exp_q.size() == 0) chk("rd_unexpected", 32'(d), 32'hFFFF_FFFF);
            else chk("rd_data", 32'(d), 32'(exp_q.pop_front()));
         end
      end
   end

   initial begin
      @(posedge clk);
      #2;
      step(0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0);
      chk("reset_out", 32'(outData), 32'h0);
      for (int i = 1; i <= 8; i++) begin
         step(1, 0, 1, 0, W'(i));
`ifdef PARAM_FIFO_FWFT_EN
         if (i == 1) chk("fwft_first", 32'(outData), 32'h01);
`else
         if (i == 1) chk("reg_idle_out", 32'(outData), 32'h00);
`endif
      end
      step(1, 0, 1, 0, 8'hFF);
      step(1, 0, 1, 1, 8'hEE);
      step(1, 0, 1, 0, 8'hEE);
      for (int i = 0; i < 8; i++) begin
         step(1, 0, 0, 1, 0);
`ifndef PARAM_FIFO_FWFT_EN
         if (i == 0) chk("reg_first", 32'(outData), 32'h02);
`endif
      end
      step(1, 0, 0, 1, 0);
      step(1, 0, 1, 1, 8'hA5);
      step(1, 0, 0, 0, 0);
      step(1, 1, 0, 0, 0);
      for (int i = 0; i < 4; i++) step(1, 0, 1, 0, W'($urandom));
      for (int i = 0; i < 20; i++) step(1, 0, 1, 1, W'($urandom));
      step(1, 0, 1, 0, W'($urandom));
      step(1, 1, 1, 0, 8'h77);
      step(1, 0, 0, 1, 0);
      for (int i = 0; i < 3; i++) step(1, 0, 1, 0, W'($urandom));
      step(0, 0, 1, 1, 8'h33);
      step(1, 0, 0, 1, 0);
      for (int i = 0; i < 600; i++)
         step($urandom_range(99) != 0, $urandom_range(39) == 0,
              $urandom_range(99) < 60, $urandom_range(99) < 50, W'($urandom));
      for (int i = 0; i < 10; i++) step(1, 0, 0, 1, 0);
      step(1, 0, 0, 0, 0);
      chk("drain", 32'(exp_q.size()), 32'h0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
